spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//   Converts a neuron spike train back into numbers; it is the inverse of the LIF current-to-spike encoding.
//   - Counts spike rising edges over a fixed window of 2^WIN_LOG2 cycles.
//   - Measures the inter-spike interval (ISI) between consecutive spikes.
//   - Presents each window result on a valid/ready output.
//   - Sits on the spike1/spike2 outputs of the neuron pair; used for on-chip readout of firing rate and STDP effect.
// PARAMETERS
//   WIDTH      8  width of count and ISI registers (saturating)
//   WIN_LOG2   6  window length = 2^WIN_LOG2 clock cycles (1..WIDTH+4)
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   enable     in   1      1 = decoding runs; 0 = window/ISI counters frozen
//   clear      in   1      restart current window and ISI tracking; the output register is kept
//   spike_in   in   1      spike train; a spike is a 0->1 transition of this level
//   out_valid  out  1      rate_count/isi_last hold an unconsumed window result
//   out_ready  in   1      consumer accepts the result when out_valid & out_ready
//   rate_count out  WIDTH  rising edges counted in the last completed window
//   isi_last   out  WIDTH  most recent ISI in cycles (edge to edge)
//   overrun    out  1      sticky: a window completed while out_valid was high and not accepted
// BEHAVIOUR
//   Reset (reset=1 at posedge):
//     - state=IDLE; all counters 0; spike_d=0.
//     - out_valid=0, rate_count=0, isi_last=0, overrun=0.
//     - Reset has priority over every other input, including mid-window.
//   Edge detect:
//     - edge = spike_in & ~spike_d; spike_d is registered every cycle regardless of enable.
//     - A level held high counts once.
//   FSM:
//     - IDLE -> ARM when enable=1.
//     - ARM: wait for the first edge. -> COUNT on edge; the ISI counter starts at 0.
//     - COUNT: normal operation.
//     - ARM/COUNT -> IDLE when enable=0. win_cnt, spk_cnt and isi_cnt hold their values (frozen, not cleared).
//     - IDLE -> COUNT (not ARM) on re-enable if an edge has been seen since the last reset/clear.
//   Window (ARM and COUNT):
//     - win_cnt increments every cycle.
//     - On the terminal cycle (win_cnt = 2^WIN_LOG2-1):
//       - Load rate_count <= spk_cnt + edge (saturated). An edge on the terminal cycle belongs to the closing window.
//       - Set spk_cnt <= 0 and win_cnt <= 0; out_valid <= 1.
//     - Latency: result visible the cycle after the terminal cycle.
//   Spike count: spk_cnt += edge, saturating at 2^WIDTH-1 (no wrap).
//   ISI (COUNT state):
//     - isi_cnt increments each cycle, saturating at 2^WIDTH-1.
//     - On an edge: isi_last <= isi_cnt + 1 (saturated), and isi_cnt <= 0.
//     - isi_last updates immediately, independent of the handshake.
//   Handshake:
//     - out_valid & out_ready -> out_valid <= 0, unless a terminal cycle occurs in the same cycle; then new data loads and out_valid stays 1 with no overrun.
//     - Terminal cycle with out_valid=1 & out_ready=0 -> overwrite rate_count and set overrun=1.
//     - overrun clears only on reset.
//     - rate_count is stable while out_valid=1, except on overrun.
//   clear:
//     - Sets win_cnt, spk_cnt and isi_cnt to 0; state -> ARM if enable, else IDLE.
//     - Does not touch out_valid, rate_count, isi_last or overrun.
//     - Precedence: clear overrides a terminal cycle in the same cycle (no result is produced).
//   Arithmetic: all unsigned. Saturation uses a compare against all-ones before incrementing.
// STRUCTURE
//   - Shared package snn_pkg: state encoding (IDLE=2'd0, ARM=2'd1, COUNT=2'd2) and the sat_inc helper/constant MAX_CNT.
//   - One natural sub-module: sat_counter (WIDTH, inc, clr, value), instanced for spk_cnt and isi_cnt.
//   - The window counter is plain WIN_LOG2-bit and wraps by design.
// TESTING
//   1. Reset mid-window: 20 edges, then reset=1 for one cycle -> all outputs 0 next cycle; state IDLE.
//   2. Periodic spikes: a 1-cycle pulse every 8 cycles, WIN_LOG2=6, out_ready=1.
//      -> rate_count=8 each window; isi_last=8; out_valid high for 1 cycle per 64.
//   3. spike_in held high for a full window -> rate_count=1 (only one edge).
//   4. Saturation: spike_in toggling every cycle (32 edges per 64 cycles) with WIDTH=4 -> rate_count=15.
//      A single spike followed by 300 quiet cycles -> isi_last=15.
//   5. Backpressure: out_ready=0 across two windows -> second window overwrites, overrun=1 and stays 1.
//      out_ready pulsed on a terminal cycle -> out_valid stays 1, overrun unchanged.
//   6. Boundary and controls:
//      - Edge on the terminal cycle -> counted in the closing window; the next window starts at 0.
//      - enable=0 for 10 cycles -> window end delayed by exactly 10 cycles.
//      - clear on a terminal cycle -> no result; out_valid unchanged.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron readout blocks.
//   - FSM state encodings for the spike-rate decoder (IDLE, ARM, COUNT).
//   - MAX_CNT: 32-bit all-ones reference that saturating counters mask down
//     to their own width.
//   - sat_inc(): increment that sticks at the all-ones value of a given width.
package snn_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;

  localparam logic [31:0] MAX_CNT = '1;

  // Compare against the width's all-ones value before incrementing, so a
  // saturated count never wraps back to zero. Valid for width 1..32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic        inc,
                                          input int unsigned width);
    logic [31:0] limit;
    limit = MAX_CNT >> (32 - width);
    return (inc && (value != limit)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the spike count and the inter-spike interval.
// Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      synchronous, active-high reset
//   clr    in   1      return to zero (wins over inc)
//   inc    in   1      add one, holding at all-ones
//   value  out  WIDTH  current count
module sat_counter
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  // NOTE: state is updated with non-blocking assignments only, and the reset is
  // sampled inside the clocked block so it is synchronous to clk.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else begin
      value <= WIDTH'(sat_inc(32'(value), inc, WIDTH));
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: turns a spike train back into numbers.
//   - Counts spike rising edges over a window of 2^WIN_LOG2 cycles and
//     presents each window's count on a valid/ready output.
//   - Tracks the interval between consecutive spikes (isi_last).
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   enable     in   1      1 = decoding runs; 0 = window/ISI counters frozen
//   clear      in   1      restart window and ISI tracking, keep outputs
//   spike_in   in   1      spike train; a spike is a 0->1 transition
//   out_valid  out  1      rate_count holds an unconsumed window result
//   out_ready  in   1      consumer accepts when out_valid & out_ready
//   rate_count out  WIDTH  edges counted in the last completed window
//   isi_last   out  WIDTH  most recent edge-to-edge interval in cycles
//   overrun    out  1      sticky: a result was overwritten before acceptance
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             spike_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rate_count,
  output logic [WIDTH-1:0] isi_last,
  output logic             overrun
);

  logic                spike_d;
  logic [1:0]          state;
  logic                seen_edge;   // an edge was counted since reset/clear
  logic [WIN_LOG2-1:0] win_cnt;     // wraps by design at the window length
  logic [WIDTH-1:0]    spk_cnt;
  logic [WIDTH-1:0]    isi_cnt;

  logic edge_det;
  logic run;
  logic counting;
  logic terminal;

  assign edge_det = spike_in & ~spike_d;
  assign run      = (state == ARM) || (state == COUNT);
  assign counting = (state == COUNT);
  // clear wins over the window end: that window is dropped, not reported.
  assign terminal = run && !clear && (win_cnt == '1);

  // The terminal cycle hands spk_cnt (plus any edge on that cycle) to
  // rate_count, so the counter itself simply restarts at zero.
  sat_counter #(.WIDTH(WIDTH)) u_spk_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear || terminal),
    .inc   (run && edge_det),
    .value (spk_cnt)
  );

  // Restarts on every edge (including the arming edge), counts only in COUNT.
  sat_counter #(.WIDTH(WIDTH)) u_isi_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear || (run && edge_det)),
    .inc   (counting),
    .value (isi_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_d    <= 1'b0;
      state      <= IDLE;
      seen_edge  <= 1'b0;
      win_cnt    <= '0;
      out_valid  <= 1'b0;
      rate_count <= '0;
      isi_last   <= '0;
      overrun    <= 1'b0;
    end else begin
      // Edge history follows the input even while disabled, so a level held
      // high across a pause is not counted again on resume.
      spike_d <= spike_in;

      if (clear) begin
        win_cnt   <= '0;
        seen_edge <= 1'b0;
        state     <= enable ? ARM : IDLE;
      end else begin
        if (run) begin
          win_cnt <= win_cnt + WIN_LOG2'(1);
          if (edge_det) seen_edge <= 1'b1;
        end
        case (state)
          IDLE:    if (enable) state <= seen_edge ? COUNT : ARM;
          ARM:     if (!enable) state <= IDLE;
                   else if (edge_det) state <= COUNT;
          COUNT:   if (!enable) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (counting && edge_det && !clear) begin
        isi_last <= WIDTH'(sat_inc(32'(isi_cnt), 1'b1, WIDTH));
      end

      // A new result replaces the old one; it only counts as an overrun if the
      // consumer did not take the old one on this same cycle.
      if (terminal) begin
        rate_count <= WIDTH'(sat_inc(32'(spk_cnt), edge_det, WIDTH));
        out_valid  <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder. Two instances share stimulus: an 8-bit one
// (main checks) and a 4-bit one (saturation). Expected window results are
// queued when a scenario starts; a negedge monitor pops and compares each time
// a result is accepted (out_valid & out_ready).
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, clear, spike_in, out_ready;
  logic       v8, v4, ov8, ov4;
  logic [7:0] rate8, isi8;
  logic [3:0] rate4, isi4;

  spike_rate_decoder #(.WIDTH(8), .WIN_LOG2(6)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .spike_in(spike_in),
    .out_valid(v8), .out_ready(out_ready), .rate_count(rate8), .isi_last(isi8),
    .overrun(ov8)
  );

  spike_rate_decoder #(.WIDTH(4), .WIN_LOG2(6)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .spike_in(spike_in),
    .out_valid(v4), .out_ready(out_ready), .rate_count(rate4), .isi_last(isi4),
    .overrun(ov4)
  );

  typedef struct {
    int rate;
    int isi;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;
  int   checks = 0;
  int   errors = 0;
  bit   mon4_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push8(input int r, input int i);
    q8.push_back('{rate: r, isi: i});
  endtask

  task automatic push4(input int r, input int i);
    q4.push_back('{rate: r, isi: i});
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    clear    = 1'b0;
    spike_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: compares every accepted result against the queue.
  always @(negedge clk) begin
    if (out_ready && v8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8_extra: result rate=%0d isi=%0d with nothing expected", rate8, isi8);
      end else begin
        e8 = q8.pop_front();
        check("dut8_rate", rate8, e8.rate);
        check("dut8_isi", isi8, e8.isi);
      end
    end
    if (mon4_en && out_ready && v4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4_extra: result rate=%0d isi=%0d with nothing expected", rate4, isi4);
      end else begin
        e4 = q4.pop_front();
        check("dut4_rate", rate4, e4.rate);
        check("dut4_isi", isi4, e4.isi);
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; spike_in = 1'b0; out_ready = 1'b1;

    // Reset state. Cycle c below is the c-th rising edge after reset:
    // c=1 moves IDLE->ARM, windows then end on c = 1 + 64*n.
    enable = 1'b1;
    do_reset();
    check("rst_valid", v8, 0);
    check("rst_rate", rate8, 0);
    check("rst_isi", isi8, 0);
    check("rst_overrun", ov8, 0);
    check("rst_state", u_dut8.state, 0);

    // Periodic 1-cycle pulse every 8 cycles: 8 per window, ISI 8.
    out_ready = 1'b1;
    repeat (3) push8(8, 8);
    for (int c = 1; c <= 194; c++) begin
      spike_in = (c % 8 == 0) && (c <= 192);
      @(posedge clk); #1;
      if (c == 64) check("per_valid_before_end", v8, 0);
      if (c == 65) check("per_valid_at_end", v8, 1);
      if (c == 66) check("per_valid_one_cycle", v8, 0);
    end

    // Level held high for a whole window counts once; next window sees none.
    do_reset();
    push8(1, 0);
    push8(0, 0);
    for (int c = 1; c <= 130; c++) begin
      spike_in = (c >= 5) && (c <= 129);
      @(posedge clk); #1;
    end

    // Backpressure: window 1 = 8 edges, window 2 = 16 (overwrites, overrun),
    // out_ready pulsed on window 3's terminal cycle (4 edges).
    out_ready = 1'b0;
    do_reset();
    push8(16, 16);
    for (int c = 1; c <= 193; c++) begin
      spike_in  = (c <= 65) ? (c % 8 == 0) : (c <= 129) ? (c % 4 == 0) : (c % 16 == 0);
      out_ready = (c == 193);
      @(posedge clk); #1;
      if (c == 65) begin
        check("bp_w1_valid", v8, 1);
        check("bp_w1_overrun", ov8, 0);
        check("bp_w1_rate", rate8, 8);
      end
      if (c == 129) begin
        check("bp_w2_valid", v8, 1);
        check("bp_w2_overrun", ov8, 1);
        check("bp_w2_rate", rate8, 16);
      end
      if (c == 193) begin
        check("bp_w3_valid", v8, 1);
        check("bp_w3_overrun_sticky", ov8, 1);
        check("bp_w3_rate", rate8, 4);
      end
    end

    // Reset mid-window after 20 edges, with a pending result and overrun set.
    for (int c = 194; c <= 233; c++) begin
      spike_in  = (c % 2 == 0);
      out_ready = 1'b0;
      @(posedge clk); #1;
    end
    check("mid_isi_before_reset", isi8, 2);
    do_reset();
    check("mid_rst_valid", v8, 0);
    check("mid_rst_rate", rate8, 0);
    check("mid_rst_isi", isi8, 0);
    check("mid_rst_overrun", ov8, 0);
    check("mid_rst_state", u_dut8.state, 0);

    // Saturation: 32 edges in window 1 (4-bit count sticks at 15), then a
    // spike at 70 and the next one 301 cycles later (4-bit ISI sticks at 15).
    out_ready = 1'b1;
    do_reset();
    mon4_en = 1'b1;
    push8(32, 2);  push4(15, 2);
    push8(1, 6);   push4(1, 6);
    repeat (3) begin push8(0, 6); push4(0, 6); end
    push8(1, 255); push4(1, 15);
    for (int c = 1; c <= 386; c++) begin
      spike_in = ((c <= 64) && (c % 2 == 0)) || (c == 70) || (c == 371);
      @(posedge clk); #1;
    end
    mon4_en = 1'b0;

    // Boundaries: edge on a terminal cycle, a 10-cycle enable gap, out_ready
    // pulsed on a terminal cycle without prior overrun, clear on a terminal.
    out_ready = 1'b1;
    do_reset();
    push8(2, 55);   // edges 10, 65 (65 is the terminal cycle)
    push8(0, 55);   // next window starts from 0
    push8(1, 85);   // edge 160; ISI frozen 10 cycles (would be 95)
    push8(2, 80);   // edges 210, 220; accepted after the edge at 300
    push8(1, 80);   // edge 300
    push8(1, 10);   // after clear; arming edge leaves isi_last alone
    for (int c = 1; c <= 460; c++) begin
      spike_in  = (c == 10) || (c == 65) || (c == 160) || (c == 210) || (c == 220) ||
                  (c == 300) || (c == 350) || (c == 360) || (c == 420);
      enable    = !((c >= 140) && (c <= 149));
      out_ready = !((c >= 205) && (c <= 330));
      clear     = (c == 395);
      @(posedge clk); #1;
      if (c == 202) check("gap_no_early_end", v8, 0);
      if (c == 203) check("gap_delayed_end", v8, 1);
      if (c == 267) begin
        check("hs_w4_valid", v8, 1);
        check("hs_w4_overrun", ov8, 0);
      end
      if (c == 331) begin
        check("hs_term_valid_stays", v8, 1);
        check("hs_term_no_overrun", ov8, 0);
        check("hs_term_rate", rate8, 1);
      end
      if (c == 395) begin
        check("clr_term_no_valid", v8, 0);
        check("clr_term_rate_kept", rate8, 1);
      end
      if (c == 458) check("clr_restart_not_yet", v8, 0);
      if (c == 459) check("clr_restart_end", v8, 1);
    end
    clear    = 1'b0;
    spike_in = 1'b0;

    check("dut8_results_left", q8.size(), 0);
    check("dut4_results_left", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
